alarm_controller: RTL and testbench

- Sequences the alarm function of the clock.
- Watches the running time against the stored alarm setting from the adjust block.
- Runs a ring / snooze / timeout state machine and drives the buzzer and status LEDs.
- Sits between the adjust block (time/alarm registers, adjusting flag) and the board outputs; timing comes from a 1 Hz single-clock pulse.

---
 rtl/alarm_controller.sv | 169 ++++++++++++++++
 tb/tb_alarm_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm sequencer: compares running time against the alarm setting and
// drives the ring / snooze / timeout state machine, buzzer and status LEDs.
//
// state   | meaning
// IDLE    | armed or disarmed, waiting for a fresh time==alarm edge
// RINGING | buzzer toggling at 1 Hz, waiting for a key or the ring timeout
// SNOOZE  | buzzer silent, counting down the snooze interval
module alarm_controller #(
  parameter int SEC_PER_MIN      = 60,
  parameter int SNOOZE_MIN       = 9,
  parameter int RING_TIMEOUT_MIN = 10,
  parameter int MAX_SNOOZES      = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sec_tick,
  input  logic       alarm_enable,
  input  logic       adjusting,
  input  logic [4:0] time_hours,
  input  logic [5:0] time_minutes,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       key_snooze,
  input  logic       key_stop,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic       missed,
  output logic [1:0] snooze_count,
  output logic [1:0] state
);

  localparam int MAX_MIN = (SNOOZE_MIN > RING_TIMEOUT_MIN) ? SNOOZE_MIN : RING_TIMEOUT_MIN;
  localparam int CW      = $clog2(MAX_MIN * SEC_PER_MIN + 1);

  localparam logic [CW-1:0] RING_LIM   = CW'(RING_TIMEOUT_MIN * SEC_PER_MIN);
  localparam logic [CW-1:0] SNOOZE_LIM = CW'(SNOOZE_MIN * SEC_PER_MIN);
  localparam logic [1:0]    SNZ_MAX    = 2'(MAX_SNOOZES);

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_RINGING = 2'b01;
  localparam logic [1:0] S_SNOOZE  = 2'b10;

  logic [1:0]    r_state, w_state_nxt;
  logic          r_match_d;
  logic          r_buzzer, w_buzzer_nxt;
  logic          r_missed, w_missed_nxt;
  logic [1:0]    r_snz_cnt, w_snz_cnt_nxt;
  logic [CW-1:0] r_sec_cnt, w_sec_cnt_nxt;

  logic w_match;
  logic w_trigger;
  logic w_ring_exp;
  logic w_snz_exp;
  logic w_snz_ok;

  assign w_match    = (time_hours == alarm_hours) && (time_minutes == alarm_minutes);
  // Edge detect: the edge is consumed in any state, so a suppressed match never rings later.
  assign w_trigger  = w_match && !r_match_d && alarm_enable && !adjusting && (r_state == S_IDLE);
  assign w_ring_exp = (r_sec_cnt == RING_LIM);
  assign w_snz_exp  = (r_sec_cnt == SNOOZE_LIM);
  assign w_snz_ok   = key_snooze && (r_snz_cnt < SNZ_MAX);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode; disarm beats keys, keys beat expiry, expiry beats snooze.
  always_comb begin
    w_state_nxt = r_state;
    if (!alarm_enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_trigger) w_state_nxt = S_RINGING;
        S_RINGING: begin
          if (key_stop)        w_state_nxt = S_IDLE;
          else if (w_ring_exp) w_state_nxt = S_IDLE;
          else if (w_snz_ok)   w_state_nxt = S_SNOOZE;
        end
        S_SNOOZE: begin
          if (key_stop)       w_state_nxt = S_IDLE;
          else if (w_snz_exp) w_state_nxt = S_RINGING;
        end
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Next values for the registered outputs and the second counter.
  always_comb begin
    w_buzzer_nxt  = r_buzzer;
    w_sec_cnt_nxt = r_sec_cnt;
    w_snz_cnt_nxt = r_snz_cnt;
    w_missed_nxt  = r_missed;
    if (key_stop || key_snooze) w_missed_nxt = 1'b0;
    if (!alarm_enable) begin
      w_buzzer_nxt  = 1'b0;
      w_sec_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_RINGING: begin
          if (key_stop) begin
            w_buzzer_nxt  = 1'b0;
            w_sec_cnt_nxt = '0;
          end else if (w_ring_exp) begin
            w_buzzer_nxt  = 1'b0;
            w_sec_cnt_nxt = '0;
            w_missed_nxt  = 1'b1;
          end else if (w_snz_ok) begin
            w_buzzer_nxt  = 1'b0;
            w_sec_cnt_nxt = '0;
            w_snz_cnt_nxt = r_snz_cnt + 2'd1;
          end else if (sec_tick) begin
            w_buzzer_nxt  = ~r_buzzer;
            w_sec_cnt_nxt = r_sec_cnt + 1'b1;
          end
        end
        S_SNOOZE: begin
          w_buzzer_nxt = 1'b0;
          if (key_stop) begin
            w_sec_cnt_nxt = '0;
          end else if (w_snz_exp) begin
            w_buzzer_nxt  = 1'b1;
            w_sec_cnt_nxt = '0;
          end else if (sec_tick) begin
            w_sec_cnt_nxt = r_sec_cnt + 1'b1;
          end
        end
        default: begin
          w_buzzer_nxt  = 1'b0;
          w_sec_cnt_nxt = '0;
          if (w_trigger) begin
            w_buzzer_nxt  = 1'b1;
            w_snz_cnt_nxt = 2'd0;
            w_missed_nxt  = 1'b0;
          end
        end
      endcase
    end
  end

  // Datapath registers; match_d resets high so a match at reset release is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_match_d <= 1'b1;
      r_buzzer  <= 1'b0;
      r_missed  <= 1'b0;
      r_snz_cnt <= 2'd0;
      r_sec_cnt <= '0;
    end else begin
      r_match_d <= w_match;
      r_buzzer  <= w_buzzer_nxt;
      r_missed  <= w_missed_nxt;
      r_snz_cnt <= w_snz_cnt_nxt;
      r_sec_cnt <= w_sec_cnt_nxt;
    end
  end

  assign state        = r_state;
  assign ringing      = (r_state == S_RINGING);
  assign snoozing     = (r_state == S_SNOOZE);
  assign buzzer       = r_buzzer;
  assign missed       = r_missed;
  assign snooze_count = r_snz_cnt;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with shortened minutes.
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sec_tick;
  logic       alarm_enable;
  logic       adjusting;
  logic [4:0] time_hours;
  logic [5:0] time_minutes;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       key_snooze;
  logic       key_stop;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic       missed;
  logic [1:0] snooze_count;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  alarm_controller #(
    .SEC_PER_MIN(4), .SNOOZE_MIN(1), .RING_TIMEOUT_MIN(2), .MAX_SNOOZES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sec_tick(sec_tick),
    .alarm_enable(alarm_enable), .adjusting(adjusting),
    .time_hours(time_hours), .time_minutes(time_minutes),
    .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .key_snooze(key_snooze), .key_stop(key_stop),
    .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing),
    .missed(missed), .snooze_count(snooze_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sec();
    sec_tick = 1'b1;
    step(1);
    sec_tick = 1'b0;
  endtask

  task automatic press_stop();
    key_stop = 1'b1;
    step(1);
    key_stop = 1'b0;
  endtask

  task automatic press_snooze();
    key_snooze = 1'b1;
    step(1);
    key_snooze = 1'b0;
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m);
    time_hours   = h;
    time_minutes = m;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walk the clock 05:59 -> 06:00 so a fresh match edge appears.
  task automatic ring_0600();
    set_time(5'd5, 6'd59);
    step(1);
    set_time(5'd6, 6'd0);
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; sec_tick = 1'b0; alarm_enable = 1'b1; adjusting = 1'b0;
    key_snooze = 1'b0; key_stop = 1'b0;
    alarm_hours = 5'd6; alarm_minutes = 6'd0;
    set_time(5'd5, 6'd59);
    step(2);
    check("rst_state",  8'(state), 8'h0);
    check("rst_buzzer", 8'(buzzer), 8'h0);
    check("rst_missed", 8'(missed), 8'h0);
    check("rst_snzcnt", 8'(snooze_count), 8'h0);
    reset_n = 1'b1;
    step(1);

    // Basic ring with one-clock latency and 1 Hz toggle.
    set_time(5'd6, 6'd0);
    step(1);
    check("ring_state",  8'(state), 8'h1);
    check("ring_ringing", 8'(ringing), 8'h1);
    check("ring_buzzer", 8'(buzzer), 8'h1);
    sec();
    check("tog1_buzzer", 8'(buzzer), 8'h0);
    sec();
    check("tog2_buzzer", 8'(buzzer), 8'h1);
    press_stop();
    check("stop_state",  8'(state), 8'h0);
    check("stop_buzzer", 8'(buzzer), 8'h0);
    step(3);
    check("stop_no_retrig", 8'(state), 8'h0);

    // Editing onto the alarm time never rings.
    set_time(5'd5, 6'd59);
    step(1);
    adjusting = 1'b1;
    set_time(5'd6, 6'd0);
    step(2);
    check("adj_no_ring", 8'(state), 8'h0);
    adjusting = 1'b0;
    step(2);
    check("adj_release_no_ring", 8'(state), 8'h0);

    // Snooze cycle up to the snooze limit.
    ring_0600();
    check("snz_ring", 8'(state), 8'h1);
    press_snooze();
    check("snz1_state",  8'(state), 8'h2);
    check("snz1_snoozing", 8'(snoozing), 8'h1);
    check("snz1_count",  8'(snooze_count), 8'h1);
    check("snz1_buzzer", 8'(buzzer), 8'h0);
    repeat (4) sec();
    check("snz1_still", 8'(state), 8'h2);
    step(1);
    check("snz1_expire_state",  8'(state), 8'h1);
    check("snz1_expire_buzzer", 8'(buzzer), 8'h1);
    check("snz1_expire_count",  8'(snooze_count), 8'h1);
    press_snooze();
    check("snz2_state", 8'(state), 8'h2);
    check("snz2_count", 8'(snooze_count), 8'h2);
    repeat (4) sec();
    step(1);
    check("snz2_expire_state", 8'(state), 8'h1);
    press_snooze();
    check("snz3_ignored_state", 8'(state), 8'h1);
    check("snz3_ignored_count", 8'(snooze_count), 8'h2);
    press_stop();
    check("snz_stop_state", 8'(state), 8'h0);
    check("snz_stop_count", 8'(snooze_count), 8'h2);

    // Unanswered ring times out; snooze on the timeout cycle loses.
    ring_0600();
    check("to_ring_state", 8'(state), 8'h1);
    check("to_ring_count", 8'(snooze_count), 8'h0);
    repeat (7) sec();
    check("to_before", 8'(state), 8'h1);
    sec();
    check("to_at_limit", 8'(state), 8'h1);
    press_snooze();
    check("to_state",  8'(state), 8'h0);
    check("to_missed", 8'(missed), 8'h1);
    check("to_buzzer", 8'(buzzer), 8'h0);
    press_stop();
    check("to_missed_clr", 8'(missed), 8'h0);

    // Stop and snooze together while ringing; then disarm while ringing.
    ring_0600();
    press_snooze();
    repeat (4) sec();
    step(1);
    check("both_ring", 8'(state), 8'h1);
    key_stop = 1'b1; key_snooze = 1'b1;
    step(1);
    key_stop = 1'b0; key_snooze = 1'b0;
    check("both_state", 8'(state), 8'h0);
    check("both_count", 8'(snooze_count), 8'h1);
    ring_0600();
    check("dis_ring", 8'(state), 8'h1);
    alarm_enable = 1'b0;
    step(1);
    check("dis_state",  8'(state), 8'h0);
    check("dis_buzzer", 8'(buzzer), 8'h0);
    alarm_enable = 1'b1;

    // Match present across reset release does not ring.
    reset_n = 1'b0;
    alarm_hours = 5'd12; alarm_minutes = 6'd0;
    set_time(5'd12, 6'd0);
    step(2);
    reset_n = 1'b1;
    step(3);
    check("rstmatch_no_ring", 8'(state), 8'h0);

    // Asynchronous reset in the middle of a snooze.
    set_time(5'd11, 6'd59);
    step(1);
    set_time(5'd12, 6'd0);
    step(1);
    press_snooze();
    check("arst_pre_state", 8'(state), 8'h2);
    check("arst_pre_count", 8'(snooze_count), 8'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_state", 8'(state), 8'h0);
    check("arst_count", 8'(snooze_count), 8'h0);
    reset_n = 1'b1;
    step(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
